sprite_pixel_compositor: RTL and testbench
==========================================

SPRITE_PIXEL_COMPOSITOR -- requirements
Module: sprite_pixel_compositor

Interface
REQ-001 SHALL have parameter SPRITE_COUNT, default 32, number of sprite result slots.
REQ-002 SHALL have parameter TRANSPARENT_KEY, default 16'hF81F, RGB565 value treated as transparent.
REQ-003 SHALL have parameter DEBUG_COLOR, default 16'hFFFF, colour driven on border pixels in debug mode.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pixel_valid, input, 1, current pixel and sprite results valid this cycle.
REQ-007 SHALL have port sprite_results, input, SPRITE_COUNT*18, slot j at [18j+17:18j] = {id[8:0], off_x[3:0], off_y[3:0], border}; an all-zero slot means not visible.
REQ-008 SHALL have port bg_color, input, 16, background RGB565 for the current pixel.
REQ-009 SHALL have port border_debug_en, input, 1, selects border highlight mode.
REQ-010 SHALL have port mem_rd, output, 1, sprite pixel memory read strobe.
REQ-011 SHALL have port mem_addr, output, 17, {id, off_y, off_x}.
REQ-012 SHALL have port mem_rdata, input, 16, RGB565 data returned exactly one cycle after mem_rd.
REQ-013 SHALL have port out_valid, output, 1, qualifies out_color.
REQ-014 SHALL have port out_color, output, 16, composited RGB565 pixel.
REQ-015 SHALL have ports write, read (1 each), address (2), writedata (32), readdata (32); control slave with zero read wait states and readdata registered.
REQ-016 SHALL have port irq, output, 1, collision interrupt.

Function
REQ-017 Stage 1, the cycle after pixel_valid: SHALL register the lowest-index slot with id != 0 (hit=1), its fields, bg_color, and visible_count >= 2.
REQ-018 Stage 2: SHALL assert mem_rd with mem_addr for the stage-1 sprite only when the stage-1 pixel was valid and hit=1; mem_rd otherwise 0 and mem_addr holds its value.
REQ-019 Stage 3: out_valid SHALL assert exactly 3 cycles after its pixel_valid; back-to-back pixels produce back-to-back outputs.
REQ-020 out_color SHALL be DEBUG_COLOR if border_debug_en (sampled in stage 1) and border=1; else mem_rdata if hit=1 and mem_rdata != TRANSPARENT_KEY; else the delayed bg_color.
REQ-021 A pixel with no visible slot SHALL output bg_color and SHALL NOT issue a memory read.
REQ-022 The collision flag SHALL become 1 on any valid pixel where the count of nonzero-id slots is >= 2, and SHALL stay 1 until cleared.
REQ-023 The collision counter (16 bits) SHALL increment once per such pixel and saturate at 16'hFFFF.
REQ-024 Register map: 0 = status (bit0 flag, RW1C); 1 = counter (RO; any write clears it); 2 = ctrl (bit0 irq_en); 3 reads 0.
REQ-025 When a clear and a new collision occur in the same cycle, the flag SHALL end at 1 and the counter SHALL end at 1.
REQ-026 irq SHALL equal flag AND irq_en, registered.
REQ-027 pixel_valid=0 cycles SHALL propagate as out_valid=0 and SHALL NOT affect collision state.

Reset
REQ-028 While reset_n=0, all pipeline valids, mem_rd, out_valid, out_color, mem_addr, readdata, flag, counter, irq_en and irq SHALL be 0; reset asserted mid-pipeline discards in-flight pixels.

Structure
REQ-029 The slot field offsets/widths, register addresses and TRANSPARENT_KEY default SHALL live in shared package vpu_pkg.
REQ-030 The lowest-index priority selector and population counter SHALL form one sub-module, sprite_priority_select.

Verification
REQ-031 Slots 3 and 7 visible (id 5, 9), off (2,4), mem_rdata 16'h1234 -> mem_addr {5,4,2}, out_color 16'h1234 three cycles later; flag=1, counter=1.
REQ-032 Only slot 0 visible, mem_rdata=16'hF81F, bg 16'h00AA -> out_color 16'h00AA.
REQ-033 No visible slots, 10 consecutive valid pixels -> mem_rd never asserted; 10 outputs equal to bg, contiguous.
REQ-034 border_debug_en=1, selected slot border=1 -> out_color 16'hFFFF regardless of mem_rdata.
REQ-035 irq_en=1, collision pixel, then a write of 1 to status in the same cycle as a new collision -> flag remains 1, counter=1, irq stays 1.
REQ-036 reset_n pulsed with 2 pixels in flight -> no out_valid after release until new input.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared definitions for the video pipeline: sprite result slot layout,
// control register addresses and pipeline stage records.
package vpu_pkg;

  localparam int SLOT_W     = 18;
  localparam int ID_W       = 9;
  localparam int OFF_W      = 4;
  localparam int ID_LSB     = 9;
  localparam int OFFX_LSB   = 5;
  localparam int OFFY_LSB   = 1;
  localparam int BORDER_BIT = 0;
  localparam int COLOR_W    = 16;
  localparam int MEM_ADDR_W = ID_W + 2 * OFF_W;

  localparam logic [COLOR_W-1:0] TRANSPARENT_KEY_DEFAULT = 16'hF81F;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [OFF_W-1:0] off_x;
    logic [OFF_W-1:0] off_y;
    logic             border;
  } sprite_slot_t;

  typedef struct packed {
    logic               valid;
    logic               hit;
    sprite_slot_t       slot;
    logic [COLOR_W-1:0] bg;
    logic               force_dbg;
    logic               multi;
  } stage1_t;

  typedef struct packed {
    logic               valid;
    logic               hit;
    logic               force_dbg;
    logic [COLOR_W-1:0] bg;
  } stage2_t;

  function automatic sprite_slot_t unpack_slot(input logic [SLOT_W-1:0] raw);
    sprite_slot_t s;
    s.id     = raw[ID_LSB +: ID_W];
    s.off_x  = raw[OFFX_LSB +: OFF_W];
    s.off_y  = raw[OFFY_LSB +: OFF_W];
    s.border = raw[BORDER_BIT];
    return s;
  endfunction

endpackage

// File: rtl/sprite_priority_select.sv
// Picks the lowest-index sprite slot with a nonzero id and reports whether
// two or more slots are visible on the current pixel.
module sprite_priority_select
  import vpu_pkg::*;
#(
  parameter int SPRITE_COUNT = 32
) (
  input  logic [SPRITE_COUNT*SLOT_W-1:0] sprite_results,
  output logic                           hit,
  output logic [SLOT_W-1:0]              slot,
  output logic                           multi
);

  sprite_slot_t cur;
  logic [1:0]   seen;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    hit  = 1'b0;
    slot = '0;
    seen = 2'd0;
    cur  = '0;
    for (int j = 0; j < SPRITE_COUNT; j++) begin
      cur = unpack_slot(sprite_results[j*SLOT_W +: SLOT_W]);
      if (cur.id != '0) begin
        if (!hit) begin
          hit  = 1'b1;
          slot = cur;
        end
        // Population count only needs to know "two or more", so it saturates at 2.
        if (seen != 2'd2) seen = seen + 2'd1;
      end
    end
    multi = (seen == 2'd2);
  end

endmodule

// File: rtl/sprite_pixel_compositor.sv
// Three-stage sprite compositor: select sprite, fetch its pixel, then blend
// against background; also tracks sprite collisions behind a small register slave.
module sprite_pixel_compositor
  import vpu_pkg::*;
#(
  parameter int          SPRITE_COUNT    = 32,
  parameter logic [15:0] TRANSPARENT_KEY = TRANSPARENT_KEY_DEFAULT,
  parameter logic [15:0] DEBUG_COLOR     = 16'hFFFF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pixel_valid,
  input  logic [SPRITE_COUNT*SLOT_W-1:0] sprite_results,
  input  logic [15:0]                    bg_color,
  input  logic                           border_debug_en,
  output logic                           mem_rd,
  output logic [16:0]                    mem_addr,
  input  logic [15:0]                    mem_rdata,
  output logic                           out_valid,
  output logic [15:0]                    out_color,
  input  logic                           write,
  input  logic                           read,
  input  logic [1:0]                     address,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  output logic                           irq
);

  logic              sel_hit;
  logic              sel_multi;
  logic [SLOT_W-1:0] sel_slot;

  stage1_t           s1_d, s1_q;
  stage2_t           s2_d, s2_q, s3_d, s3_q;
  logic              mem_rd_d, mem_rd_q;
  logic [16:0]       mem_addr_d, mem_addr_q;
  logic              flag_d, flag_q;
  logic [15:0]       count_d, count_q;
  logic              irq_en_d, irq_en_q;
  logic              irq_d, irq_q;
  logic [31:0]       readdata_d, readdata_q;
  logic              collision;
  logic              unused_wdata;

  sprite_priority_select #(
    .SPRITE_COUNT (SPRITE_COUNT)
  ) u_select (
    .sprite_results (sprite_results),
    .hit            (sel_hit),
    .slot           (sel_slot),
    .multi          (sel_multi)
  );

  assign unused_wdata = ^writedata[31:1];
  assign collision    = s1_q.valid & s1_q.multi;

  always_comb begin
    s1_d = '0;
    if (pixel_valid) begin
      s1_d.valid     = 1'b1;
      s1_d.hit       = sel_hit;
      s1_d.slot      = sprite_slot_t'(sel_slot);
      s1_d.bg        = bg_color;
      s1_d.force_dbg = border_debug_en & sel_slot[BORDER_BIT];
      s1_d.multi     = sel_multi;
    end

    s2_d.valid     = s1_q.valid;
    s2_d.hit       = s1_q.hit;
    s2_d.force_dbg = s1_q.force_dbg;
    s2_d.bg        = s1_q.bg;
    s3_d           = s2_q;

    mem_rd_d   = s1_q.valid & s1_q.hit;
    mem_addr_d = mem_rd_d ? {s1_q.slot.id, s1_q.slot.off_y, s1_q.slot.off_x} : mem_addr_q;

    // A clear and a collision landing together: the clear applies first, then the event.
    flag_d  = flag_q;
    count_d = count_q;
    if (write && address == REG_STATUS && writedata[0]) flag_d = 1'b0;
    if (write && address == REG_COUNT) count_d = '0;
    if (collision) begin
      flag_d = 1'b1;
      if (count_d != 16'hFFFF) count_d = count_d + 16'd1;
    end

    irq_en_d = irq_en_q;
    if (write && address == REG_CTRL) irq_en_d = writedata[0];
    irq_d = flag_q & irq_en_q;

    readdata_d = readdata_q;
    if (read) begin
      case (address)
        REG_STATUS: readdata_d = {31'd0, flag_q};
        REG_COUNT:  readdata_d = {16'd0, count_q};
        REG_CTRL:   readdata_d = {31'd0, irq_en_q};
        default:    readdata_d = '0;
      endcase
    end
  end

  // Memory data arrives in the stage-3 cycle, so the final blend is combinational.
  always_comb begin
    out_color = '0;
    if (s3_q.valid) begin
      if (s3_q.force_dbg)                               out_color = DEBUG_COLOR;
      else if (s3_q.hit && mem_rdata != TRANSPARENT_KEY) out_color = mem_rdata;
      else                                              out_color = s3_q.bg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      flag_q     <= 1'b0;
      count_q    <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      flag_q     <= flag_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = s3_q.valid;
  assign irq       = irq_q;
  assign readdata  = readdata_q;

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Scoreboard bench for sprite_pixel_compositor: a reference model predicts memory
// reads and output pixels at drive time; a negedge monitor pops and compares.
module tb_sprite_pixel_compositor;
  import vpu_pkg::*;

  localparam int SC = 32;
  localparam int SW = SC * 18;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [SW-1:0] sprite_results = '0;
  logic [15:0]   bg_color = '0;
  logic          border_debug_en = 1'b0;
  logic          mem_rd;
  logic [16:0]   mem_addr;
  logic [15:0]   mem_rdata = 16'hBAD0;
  logic          out_valid;
  logic [15:0]   out_color;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [1:0]    address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;

  sprite_pixel_compositor #(
    .SPRITE_COUNT    (SC),
    .TRANSPARENT_KEY (16'hF81F),
    .DEBUG_COLOR     (16'hFFFF)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pixel_valid     (pixel_valid),
    .sprite_results  (sprite_results),
    .bg_color        (bg_color),
    .border_debug_en (border_debug_en),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .out_valid       (out_valid),
    .out_color       (out_color),
    .write           (write),
    .read            (read),
    .address         (address),
    .writedata       (writedata),
    .readdata        (readdata),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          mem_mode = 0;
  logic [15:0] mem_fixed = 16'h0000;

  function automatic logic [15:0] mem_model(input logic [16:0] a);
    if (mem_mode == 0) return mem_fixed;
    return a[15:0] ^ 16'h3C5A;
  endfunction

  always @(posedge clk) mem_rdata <= mem_rd ? mem_model(mem_addr) : 16'hBAD0;

  typedef struct {logic [15:0] color; int cyc;} out_exp_t;
  typedef struct {logic [16:0] addr;  int cyc;} rd_exp_t;
  out_exp_t out_q[$];
  rd_exp_t  rd_q[$];
  out_exp_t oe;
  rd_exp_t  re;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int run_len = 0, max_run = 0, out_seen = 0, rd_seen = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_rd) begin
        rd_seen++;
        if (rd_q.size() == 0) check("mem_rd_unexpected", 32'd1, 32'd0);
        else begin
          re = rd_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(re.addr));
          check("mem_rd_latency", cyc - re.cyc, 32'd2);
        end
      end
      if (out_valid) begin
        out_seen++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (out_q.size() == 0) check("out_valid_unexpected", 32'd1, 32'd0);
        else begin
          oe = out_q.pop_front();
          check("out_color", 32'(out_color), 32'(oe.color));
          check("out_latency", cyc - oe.cyc, 32'd3);
        end
      end else begin
        run_len = 0;
      end
    end
  end

  logic        model_flag = 1'b0;
  logic [15:0] model_cnt  = '0;
  logic        model_irq_en = 1'b0;
  logic [SW-1:0] sv;
  logic [31:0] rd;

  function automatic logic [17:0] mk(input int id, input int ox, input int oy, input int b);
    return {9'(id), 4'(ox), 4'(oy), 1'(b)};
  endfunction

  task automatic put(input int j, input logic [17:0] v);
    sv[j*18 +: 18] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: lowest nonzero-id slot wins; debug border beats memory, memory beats bg.
  task automatic drive_pixel(input logic [SW-1:0] s, input logic [15:0] bg, input logic dbg);
    int          first;
    int          cnt;
    logic [17:0] sl;
    logic [16:0] a;
    logic [15:0] d, c;
    first = -1;
    cnt   = 0;
    for (int j = 0; j < SC; j++) begin
      sl = s[j*18 +: 18];
      if (sl[17:9] != 9'd0) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
    c = bg;
    if (first >= 0) begin
      sl = s[first*18 +: 18];
      a  = {sl[17:9], sl[4:1], sl[8:5]};
      rd_q.push_back('{a, cyc});
      d = mem_model(a);
      if (dbg && sl[0])        c = 16'hFFFF;
      else if (d != 16'hF81F)  c = d;
    end
    out_q.push_back('{c, cyc});
    if (cnt >= 2) begin
      model_flag = 1'b1;
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end
    sprite_results  = s;
    bg_color        = bg;
    border_debug_en = dbg;
    pixel_valid     = 1'b1;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    d    = readdata;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while ((out_q.size() != 0 || rd_q.size() != 0) && budget < 20) begin
      idle(1);
      budget++;
    end
    check(tag, out_q.size() + rd_q.size(), 32'd0);
    idle(1);
  endtask

  task automatic check_regs(input string tag);
    reg_read(REG_STATUS, rd);
    check({tag, "_flag"}, rd, {31'd0, model_flag});
    reg_read(REG_COUNT, rd);
    check({tag, "_count"}, rd, {16'd0, model_cnt});
  endtask

  initial begin
    int base_rd, base_out;

    // Reset state
    idle(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    check("rst_mem_rd",    32'(mem_rd),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_readdata",  readdata,       32'd0);
    check("rst_irq",       32'(irq),       32'd0);
    reset_n = 1'b1;
    idle(2);
    check_regs("rst");

    // Two visible slots: lowest index wins and a collision is recorded
    mem_mode = 0; mem_fixed = 16'h1234;
    sv = '0; put(3, mk(5, 2, 4, 0)); put(7, mk(9, 1, 1, 0));
    drive_pixel(sv, 16'h0101, 1'b0);
    drain("drain_collide");
    check_regs("collide");

    // Transparent sprite pixel shows the background
    mem_fixed = 16'hF81F;
    sv = '0; put(0, mk(3, 7, 9, 0));
    drive_pixel(sv, 16'h00AA, 1'b0);
    drain("drain_transparent");

    // No visible slot: background only, no memory traffic, contiguous output
    base_rd = rd_seen;
    max_run = 0;
    sv = '0;
    for (int i = 0; i < 10; i++) drive_pixel(sv, 16'(i * 16'h0111 + 16'h0007), 1'b0);
    drain("drain_empty");
    check("empty_no_mem_rd", rd_seen - base_rd, 32'd0);
    check("empty_contiguous", 32'(max_run >= 10), 32'd1);

    // Border debug highlight, and its two non-triggering neighbours
    mem_fixed = 16'h4321;
    sv = '0; put(4, mk(17, 3, 5, 1)); put(9, mk(2, 0, 0, 0));
    drive_pixel(sv, 16'h0F0F, 1'b1);
    drive_pixel(sv, 16'h0F0F, 1'b0);
    sv = '0; put(4, mk(17, 3, 5, 0)); put(9, mk(2, 0, 0, 1));
    drive_pixel(sv, 16'h0F0F, 1'b1);
    drain("drain_debug");

    // Randomised traffic with address-dependent memory contents and idle gaps
    mem_mode = 1;
    for (int i = 0; i < 40; i++) begin
      sv = '0;
      repeat ($urandom_range(0, 3))
        put($urandom_range(0, SC - 1),
            mk($urandom_range(1, 511), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
      drive_pixel(sv, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain("drain_random");
    check_regs("random");

    // Control register and unmapped address
    reg_write(REG_CTRL, 32'd1); model_irq_en = 1'b1;
    reg_read(REG_CTRL, rd);
    check("ctrl_readback", rd, {31'd0, model_irq_en});
    reg_read(2'd3, rd);
    check("addr3_zero", rd, 32'd0);

    // Status clear racing a new collision; counter cleared beforehand
    mem_mode = 0; mem_fixed = 16'h2222;
    reg_write(REG_COUNT, 32'd0);  model_cnt = '0;
    reg_write(REG_STATUS, 32'd1); model_flag = 1'b0;
    idle(2);
    check("irq_low_after_clear", 32'(irq), 32'd0);
    sv = '0; put(1, mk(40, 1, 2, 0)); put(2, mk(41, 3, 4, 0));
    drive_pixel(sv, 16'h0001, 1'b0);
    idle(3);
    check("irq_after_collision", 32'(irq), 32'd1);
    reg_write(REG_COUNT, 32'd0); model_cnt = '0;
    drive_pixel(sv, 16'h0002, 1'b0);
    reg_write(REG_STATUS, 32'd1);  // lands with the collision, which dominates
    for (int i = 0; i < 4; i++) begin
      check("irq_held", 32'(irq), 32'd1);
      idle(1);
    end
    drain("drain_race_status");
    check_regs("race_status");

    // Counter clear racing a new collision ends at one
    drive_pixel(sv, 16'h0003, 1'b0);
    reg_write(REG_COUNT, 32'd0);
    model_cnt = 16'd1;
    drain("drain_race_count");
    check_regs("race_count");

    // Writing 0 to status leaves the flag; writing 1 clears it and drops irq
    reg_write(REG_STATUS, 32'd0);
    check_regs("status_w0");
    reg_write(REG_STATUS, 32'd1); model_flag = 1'b0;
    idle(2);
    check("irq_cleared", 32'(irq), 32'd0);
    check_regs("status_w1");

    // Reset with two pixels in flight discards them
    sv = '0; put(5, mk(77, 6, 6, 0));
    drive_pixel(sv, 16'h0A0A, 1'b0);
    drive_pixel(sv, 16'h0B0B, 1'b0);
    reset_n = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_mem_rd",    32'(mem_rd),    32'd0);
    check("midrst_mem_addr",  32'(mem_addr),  32'd0);
    check("midrst_irq",       32'(irq),       32'd0);
    out_q.delete();
    rd_q.delete();
    model_flag = 1'b0; model_cnt = '0; model_irq_en = 1'b0;
    idle(2);
    reset_n = 1'b1;
    base_out = out_seen;
    base_rd  = rd_seen;
    idle(8);
    check("postrst_no_out", out_seen - base_out, 32'd0);
    check("postrst_no_rd",  rd_seen - base_rd,   32'd0);
    check_regs("postrst");
    reg_read(REG_CTRL, rd);
    check("postrst_ctrl", rd, {31'd0, model_irq_en});

    // Fresh pixel after reset flows normally
    drive_pixel(sv, 16'h0C0C, 1'b0);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
